// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, FIFO occupancy encoding and the
// parity/encode/syndrome functions reused by the downstream decoder.
package hamming_pkg;
  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

  typedef struct packed {
    logic              flip;
    logic [CODE_W-1:0] code;
  } fifo_ent_t;

  // Parity bits returned as {c6, c5, c3}.
  function automatic logic [2:0] hamming_parity(input logic [DATA_W-1:0] d);
    return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[2] ^ d[1] ^ d[0]};
  endfunction

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic [2:0] p;
    p = hamming_parity(d);
    return {p[2], p[1], d[3], p[0], d[2], d[1], d[0]};
  endfunction

  // Syndrome {s2, s1, s0}; zero for every unmodified codeword.
  function automatic logic [2:0] hamming_syndrome(input logic [CODE_W-1:0] c);
    return {c[3] ^ c[2] ^ c[1] ^ c[0],
            c[5] ^ c[4] ^ c[1] ^ c[0],
            c[6] ^ c[4] ^ c[2] ^ c[0]};
  endfunction
endpackage

// File: rtl/hamming_encoder_stream_if.sv
// Stream interface: nibble + error-injection request in, codeword out.
interface hamming_encoder_stream_if;
  import hamming_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [2:0]        inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;

  modport master (output in_valid, in_data, inj_en, inj_pos, out_ready,
                  input  in_ready, out_valid, out_code);
  modport slave  (input  in_valid, in_data, inj_en, inj_pos, out_ready,
                  output in_ready, out_valid, out_code);
endinterface

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(7,4) encoder core.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);
  assign code = hamming_encode(data);
endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(7,4) encoder with single-bit error injection, a 2-entry
// output FIFO and saturating delivery counters.
module hamming_encoder_stream
  import hamming_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  hamming_encoder_stream_if.slave  s,
  output logic [15:0]              word_count,
  output logic [7:0]               inj_count
);
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] one_hot;
  fifo_ent_t         new_ent, ent0, ent1;
  occ_t              state, state_nxt;
  logic              in_ready_q;
  logic              accept, send;

  hamming_enc_core u_enc (.data(s.in_data), .code(enc_code));

  assign one_hot = CODE_W'(1);
  assign accept  = s.in_valid && in_ready_q;
  assign send    = (state != EMPTY) && s.out_ready;

  always_comb begin
    new_ent.flip = s.inj_en && (s.inj_pos != 3'd7);
    flip_mask    = new_ent.flip ? (one_hot << s.inj_pos) : '0;
    new_ent.code = enc_code ^ flip_mask;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE:     if (accept && !send) state_nxt = TWO;
               else if (send && !accept) state_nxt = EMPTY;
      TWO:     if (send) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is a register held low through reset so nothing is accepted
  // until the first clock after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      ent0       <= '0;
      ent1       <= '0;
      word_count <= '0;
      inj_count  <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      case (state)
        EMPTY:   if (accept) ent0 <= new_ent;
        ONE:     if (accept && send) ent0 <= new_ent;
                 else if (accept) ent1 <= new_ent;
        TWO:     if (send) ent0 <= ent1;
        default: ;
      endcase
      if (send && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      if (send && ent0.flip && inj_count != 8'hFF) inj_count <= inj_count + 8'd1;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = (state != EMPTY);
  assign s.out_code  = ent0.code;
endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Scoreboard bench: the driver pushes reference codewords on accept, a
// negedge monitor pops and compares each delivered codeword and the counters.
module tb_hamming_encoder_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] word_count;
  logic [7:0]  inj_count;
  hamming_encoder_stream_if sif();

  hamming_encoder_stream dut (.clk(clk), .reset(reset), .s(sif.slave),
                              .word_count(word_count), .inj_count(inj_count));

  always #5 clk = ~clk;

  typedef struct { logic [6:0] code; bit flip; } exp_t;
  exp_t q[$];
  int   checks = 0, passed = 0;
  int   exp_words = 0, exp_inj = 0;
  bit   rnd_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [2:0] syn(input logic [6:0] c);
    return {c[3]^c[2]^c[1]^c[0], c[5]^c[4]^c[1]^c[0], c[6]^c[4]^c[2]^c[0]};
  endfunction

  // Reference: place data at positions 0,1,2,4 and search the parity
  // positions 3,5,6 for the assignment giving a zero syndrome.
  function automatic logic [6:0] model_encode(input logic [3:0] d);
    logic [6:0] c;
    for (int p = 0; p < 8; p++) begin
      c = '0;
      c[0] = d[0]; c[1] = d[1]; c[2] = d[2]; c[4] = d[3];
      c[3] = p[0]; c[5] = p[1]; c[6] = p[2];
      if (syn(c) == 3'b000) return c;
    end
    return 7'bx;
  endfunction

  task automatic send(input logic [3:0] d, input logic en, input logic [2:0] pos,
                      output int stalls);
    exp_t e;
    sif.in_valid = 1'b1; sif.in_data = d; sif.inj_en = en; sif.inj_pos = pos;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (sif.in_ready) begin
        e.flip = en && (pos != 3'd7);
        e.code = model_encode(d);
        if (e.flip) e.code[pos] = ~e.code[pos];
        q.push_back(e);
        break;
      end
      stalls++;
      if (stalls > 200) begin
        chk("accept_timeout", 32'(stalls), 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    sif.in_data = 4'($urandom); sif.inj_en = 1'($urandom); sif.inj_pos = 3'($urandom);
  endtask

  task automatic drain();
    sif.out_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every cycle the counters must match deliveries seen so far.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete(); exp_words = 0; exp_inj = 0;
    end else begin
      chk("word_count", 32'(word_count), 32'(exp_words));
      chk("inj_count", 32'(inj_count), 32'(exp_inj));
      if (sif.out_valid && sif.out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 32'(sif.out_code), 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("out_code", 32'(sif.out_code), 32'(e.code));
          if (!e.flip) chk("syndrome", 32'(syn(sif.out_code)), 0);
          if (exp_words < 16'hFFFF) exp_words++;
          if (e.flip && exp_inj < 8'hFF) exp_inj++;
        end
      end
    end
  end

  always @(posedge clk) if (rnd_mode) begin
    #1 sif.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int st, tot, wc0;
    sif.in_valid = 0; sif.in_data = 0; sif.inj_en = 0; sif.inj_pos = 0; sif.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(sif.out_valid), 0);
    chk("rst_in_ready", 32'(sif.in_ready), 0);
    chk("rst_out_code", 32'(sif.out_code), 0);
    chk("rst_word_count", 32'(word_count), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(sif.in_ready), 1);

    // Single word, latency one.
    sif.out_ready = 1'b1;
    send(4'b1011, 1'b0, 3'd7, st);
    chk("lat1_valid", 32'(sif.out_valid), 1);
    chk("lat1_code", 32'(sif.out_code), 32'(7'b0110011));
    @(posedge clk); #1;
    chk("wc_one", 32'(word_count), 1);

    send(4'h0, 1'b0, 3'd0, st);
    chk("code_all0", 32'(sif.out_code), 32'(7'b0000000));
    send(4'hF, 1'b0, 3'd0, st);
    chk("code_all1", 32'(sif.out_code), 32'(7'b1111111));

    send(4'b1011, 1'b1, 3'd3, st);
    chk("inj_pos3", 32'(sif.out_code), 32'(7'b0111011));
    @(posedge clk); #1;
    chk("inj_cnt1", 32'(inj_count), 1);
    send(4'b1011, 1'b1, 3'd7, st);
    chk("inj_pos7", 32'(sif.out_code), 32'(7'b0110011));
    @(posedge clk); #1;
    chk("inj_cnt_hold", 32'(inj_count), 1);

    // Backpressure: two accepted, third stalls until the FIFO drains.
    sif.out_ready = 1'b0;
    send(4'h3, 1'b0, 3'd0, st);
    send(4'h9, 1'b0, 3'd0, st);
    sif.in_valid = 1'b1; sif.in_data = 4'h6;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 32'(sif.in_ready), 0);
    end
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    send(4'h6, 1'b0, 3'd0, st);
    chk("third_stalled", 32'(st > 0), 1);
    drain();

    // Streaming at full rate stays in ONE.
    wc0 = word_count;
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      send(4'($urandom), 1'($urandom), 3'($urandom), st);
      tot += st;
      chk("stream_valid", 32'(sif.out_valid), 1);
    end
    chk("stream_stalls", 32'(tot), 0);
    drain();
    chk("stream_wc", 32'(word_count - 16'(wc0)), 20);

    // Random traffic with random backpressure.
    rnd_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send(4'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom), st);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_mode = 0;
    @(posedge clk); #2;
    drain();

    // Enough flipped words to saturate inj_count.
    for (int i = 0; i < 260; i++) send(4'($urandom), 1'b1, 3'($urandom_range(0, 6)), st);
    drain();
    chk("inj_sat", 32'(inj_count), 32'hFF);

    // Reset while holding two words.
    sif.out_ready = 1'b0;
    send(4'h5, 1'b0, 3'd0, st);
    send(4'hA, 1'b0, 3'd0, st);
    #1 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(sif.out_valid), 0);
    chk("midrst_in_ready", 32'(sif.in_ready), 0);
    chk("midrst_word_count", 32'(word_count), 0);
    chk("midrst_inj_count", 32'(inj_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(sif.in_ready), 1);
    sif.out_ready = 1'b1;
    repeat (3) begin
      chk("no_stale", 32'(sif.out_valid), 0);
      @(posedge clk); #1;
    end
    send(4'b1011, 1'b0, 3'd7, st);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
